// File: rtl/clock_pkg.sv
// Shared definitions for the stopwatch, countdown timer and alarm blocks:
// the limit of each display digit and the 2-bit timer state encoding.
package clock_pkg;

  // Largest legal value of each display digit (m:ss.t).
  localparam logic [3:0] D0_MAX = 4'd9;  // tenths
  localparam logic [3:0] D1_MAX = 4'd9;  // seconds units
  localparam logic [3:0] D2_MAX = 4'd5;  // seconds tens
  localparam logic [3:0] D3_MAX = 4'd9;  // minutes

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Clamp a preset digit to its legal maximum.
  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and raises tick for one cycle
// when it is sitting at DIV-1 (and wraps back to 0 on that edge).
// The count is frozen while en is low, so a paused timer keeps its phase.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  // Phase counter: cleared by reset or clr, advances only when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads a BCD m:ss.t preset, counts down once per tick
// while run is high, and flags done/expired on reaching 0:00.0.
// Every output comes straight from a register.
//
// Handshake note: there is no valid/ready pair here. load is a one-cycle
// strobe that always wins over run and over a coincident tick; run is a level.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_d0,
  input  logic [3:0] ld_d1,
  input  logic [3:0] ld_d2,
  input  logic [3:0] ld_d3,
  input  logic       run,
  output logic [3:0] reg_d0,
  output logic [3:0] reg_d1,
  output logic [3:0] reg_d2,
  output logic [3:0] reg_d3,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic [1:0] dbg_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_d0, r_d1, r_d2, r_d3;
  logic [3:0] w_d0_nxt, w_d1_nxt, w_d2_nxt, w_d3_nxt;
  logic [3:0] w_dec0, w_dec1, w_dec2, w_dec3;
  logic       w_b0, w_b1, w_b2;
  logic       r_running, r_done, r_expired;
  logic       w_done_nxt, w_expired_nxt;
  logic       w_tick;
  logic       w_zero;
  logic       w_dec_zero;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (r_state == RUN),
    .clr   (load),
    .tick  (w_tick)
  );

  assign w_zero     = ({r_d3, r_d2, r_d1, r_d0} == 16'h0000);
  assign w_dec_zero = ({w_dec3, w_dec2, w_dec1, w_dec0} == 16'h0000);

  // BCD borrow chain: the count minus one tenth.
  always_comb begin
    w_b0   = (r_d0 == 4'd0);
    w_dec0 = w_b0 ? D0_MAX : r_d0 - 4'd1;
    w_b1   = 1'b0;
    w_dec1 = r_d1;
    if (w_b0) begin
      w_b1   = (r_d1 == 4'd0);
      w_dec1 = w_b1 ? D1_MAX : r_d1 - 4'd1;
    end
    w_b2   = 1'b0;
    w_dec2 = r_d2;
    if (w_b1) begin
      w_b2   = (r_d2 == 4'd0);
      w_dec2 = w_b2 ? D2_MAX : r_d2 - 4'd1;
    end
    // Minutes cannot underflow: a tick is never applied at 0:00.0.
    w_dec3 = r_d3;
    if (w_b2) begin
      w_dec3 = r_d3 - 4'd1;
    end
  end

  // Next-state, next-digit and flag logic; load overrides everything else.
  always_comb begin
    w_state_nxt   = r_state;
    w_d0_nxt      = r_d0;
    w_d1_nxt      = r_d1;
    w_d2_nxt      = r_d2;
    w_d3_nxt      = r_d3;
    w_done_nxt    = 1'b0;
    w_expired_nxt = r_expired;
    if (load) begin
      w_d0_nxt      = sat_digit(ld_d0, D0_MAX);
      w_d1_nxt      = sat_digit(ld_d1, D1_MAX);
      w_d2_nxt      = sat_digit(ld_d2, D2_MAX);
      w_d3_nxt      = sat_digit(ld_d3, D3_MAX);
      w_state_nxt   = IDLE;
      w_expired_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A zero count never starts, so it can never expire.
          if (run && !w_zero) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (w_tick) begin
            w_d0_nxt = w_dec0;
            w_d1_nxt = w_dec1;
            w_d2_nxt = w_dec2;
            w_d3_nxt = w_dec3;
            if (w_dec_zero) begin
              w_state_nxt   = EXPIRED;
              w_done_nxt    = 1'b1;
              w_expired_nxt = 1'b1;
            end else if (!run) begin
              w_state_nxt = IDLE;
            end
          end else if (!run) begin
            w_state_nxt = IDLE;
          end
        end
        EXPIRED: begin
          w_state_nxt = EXPIRED;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, digit and output flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_d0      <= w_d0_nxt;
      r_d1      <= w_d1_nxt;
      r_d2      <= w_d2_nxt;
      r_d3      <= w_d3_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= w_done_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  assign reg_d0    = r_d0;
  assign reg_d1    = r_d1;
  assign reg_d2    = r_d2;
  assign reg_d3    = r_d3;
  assign running   = r_running;
  assign done      = r_done;
  assign expired   = r_expired;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with DIV = 10. A reference model tracks the
// count as a plain number of tenths and is compared every cycle; directed
// sequences and a preset table check the corner cases against constants.
module tb_countdown_timer;

  localparam int DIV = 10;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  logic       clk = 1'b0;
  logic       reset, load, run;
  logic [3:0] ld_d0, ld_d1, ld_d2, ld_d3;
  logic [3:0] reg_d0, reg_d1, reg_d2, reg_d3;
  logic       running, done, expired;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  countdown_timer #(.CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .ld_d0     (ld_d0),
    .ld_d1     (ld_d1),
    .ld_d2     (ld_d2),
    .ld_d3     (ld_d3),
    .run       (run),
    .reg_d0    (reg_d0),
    .reg_d1    (reg_d1),
    .reg_d2    (reg_d2),
    .reg_d3    (reg_d3),
    .running   (running),
    .done      (done),
    .expired   (expired),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  int m_tenths = 0;
  int m_phase  = 0;
  int m_mode   = M_IDLE;
  bit m_done   = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    bit tk;
    if (reset) begin
      m_tenths = 0; m_phase = 0; m_mode = M_IDLE; m_done = 1'b0;
    end else if (load) begin
      m_tenths = sat(int'(ld_d3), 9) * 600 + sat(int'(ld_d2), 5) * 100 +
                 sat(int'(ld_d1), 9) * 10 + sat(int'(ld_d0), 9);
      m_phase = 0; m_mode = M_IDLE; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode == M_IDLE) begin
        if (run && m_tenths != 0) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        tk = (m_phase == DIV - 1);
        m_phase = (m_phase + 1) % DIV;
        if (tk) begin
          m_tenths = m_tenths - 1;
          if (m_tenths == 0) begin
            m_mode = M_EXP;
            m_done = 1'b1;
          end else if (!run) begin
            m_mode = M_IDLE;
          end
        end else if (!run) begin
          m_mode = M_IDLE;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];

  function automatic logic [15:0] to_digits(input int t);
    logic [3:0] a, b, c, d;
    a = 4'(t / 600);
    b = 4'((t % 600) / 100);
    c = 4'((t % 100) / 10);
    d = 4'(t % 10);
    return {a, b, c, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    logic [18:0] act;
    logic [18:0] exp;
    exp_q.push_back({to_digits(m_tenths), m_mode == M_RUN, m_done, m_mode == M_EXP});
    exp = exp_q.pop_front();
    act = {reg_d3, reg_d2, reg_d1, reg_d0, running, done, expired};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model at %0t: got d=%h r/d/e=%b expected d=%h r/d/e=%b",
               $time, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic set_preset(input logic [3:0] d3, d2, d1, d0);
    ld_d3 = d3; ld_d2 = d2; ld_d1 = d1; ld_d0 = d0;
  endtask

  // Load a preset with run high and step into RUN.
  task automatic load_and_start(input logic [3:0] d3, d2, d1, d0);
    set_preset(d3, d2, d1, d0);
    load = 1'b1; run = 1'b1;
    cycle();
    load = 1'b0;
    cycle();
    check("enter_run", running, 1);
  endtask

  function automatic logic [15:0] dig();
    return {reg_d3, reg_d2, reg_d1, reg_d0};
  endfunction

  typedef struct {
    logic [3:0] l3, l2, l1, l0;
    logic [3:0] e3, e2, e1, e0;
  } vec_t;

  vec_t vt[6];

  initial begin
    reset = 1'b1; load = 1'b0; run = 1'b0;
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state
    cycle();
    cycle();
    check("reset_digits", dig(), 16'h0000);
    check("reset_flags", {running, done, expired}, 3'b000);
    reset = 1'b0;
    cycle();

    // Seq 1: 0:01.2 counts down at 10-cycle spacing, done after 120 cycles
    load_and_start(4'd0, 4'd0, 4'd1, 4'd2);
    for (int k = 1; k <= 12; k++) begin
      repeat (DIV) cycle();
      check("seq1_digits", dig(), {8'h00, 4'((12 - k) / 10), 4'((12 - k) % 10)});
      check("seq1_done", done, (k == 12) ? 1 : 0);
    end
    check("seq1_expired", expired, 1);
    check("seq1_running", running, 0);
    cycle();
    check("seq1_done_drop", done, 0);
    check("seq1_expired_hold", expired, 1);
    repeat (15) cycle();
    check("seq1_expired_ignores_run", {running, expired}, 2'b01);

    // Seq 2: 1:00.0 -> 0:59.9 through the full borrow chain
    load_and_start(4'd1, 4'd0, 4'd0, 4'd0);
    repeat (DIV) cycle();
    check("seq2_borrow", dig(), 16'h0599);
    run = 1'b0;
    cycle();

    // Seq 3: pause after 25 running cycles, hold 40, resume
    load_and_start(4'd0, 4'd3, 4'd0, 4'd0);
    repeat (24) cycle();
    run = 1'b0;
    cycle();
    check("seq3_paused", running, 0);
    check("seq3_digits", dig(), 16'h0298);
    repeat (40) cycle();
    check("seq3_frozen", dig(), 16'h0298);
    run = 1'b1;
    cycle();
    check("seq3_resume", running, 1);
    repeat (4) cycle();
    check("seq3_before_tick", dig(), 16'h0298);
    cycle();
    check("seq3_tick_after_5", dig(), 16'h0297);
    run = 1'b0;
    cycle();

    // Seq 4a: saturation table
    vt[0] = '{4'hF, 4'h7, 4'hC, 4'hA, 4'd9, 4'd5, 4'd9, 4'd9};
    vt[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4};
    vt[2] = '{4'd0, 4'd6, 4'd9, 4'd9, 4'd0, 4'd5, 4'd9, 4'd9};
    vt[3] = '{4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd9};
    vt[4] = '{4'hA, 4'd0, 4'd0, 4'hB, 4'd9, 4'd0, 4'd0, 4'd9};
    vt[5] = '{4'd0, 4'hE, 4'hD, 4'd0, 4'd0, 4'd5, 4'd9, 4'd0};
    for (int i = 0; i < 6; i++) begin
      set_preset(vt[i].l3, vt[i].l2, vt[i].l1, vt[i].l0);
      load = 1'b1; run = 1'b0;
      cycle();
      load = 1'b0;
      check("sat_table", dig(), {vt[i].e3, vt[i].e2, vt[i].e1, vt[i].e0});
      check("sat_flags", {running, expired}, 2'b00);
    end

    // Seq 4b: zero preset never starts or expires
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);
    load = 1'b1; run = 1'b1;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      check("zero_load_flags", {running, done, expired}, 3'b000);
    end
    run = 1'b0;
    cycle();

    // Seq 5: load coincident with the final tick wins
    load_and_start(4'd0, 4'd0, 4'd0, 4'd1);
    repeat (DIV - 1) cycle();
    set_preset(4'd0, 4'd1, 4'd0, 4'd0);
    load = 1'b1;
    cycle();
    load = 1'b0;
    check("seq5_preset_wins", dig(), 16'h0100);
    check("seq5_flags", {running, done, expired}, 3'b000);
    cycle();
    check("seq5_reenter_run", running, 1);
    run = 1'b0;
    cycle();

    // Seq 6: reset mid-run, then run=1 with zero count stays idle
    load_and_start(4'd0, 4'd3, 4'd0, 4'd5);
    repeat (5) cycle();
    reset = 1'b1;
    cycle();
    check("seq6_digits", dig(), 16'h0000);
    check("seq6_flags", {running, done, expired}, 3'b000);
    reset = 1'b0;
    repeat (5) cycle();
    check("seq6_stays_idle", running, 0);

    // Randomized phase against the model
    run = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      load  = ($urandom_range(0, 39) == 0);
      if (load) begin
        if ($urandom_range(0, 2) == 0) begin
          set_preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end else begin
          set_preset(4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 12)));
        end
      end
      if ($urandom_range(0, 29) == 0) run = ~run;
      cycle();
    end
    reset = 1'b0; load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
